// File: rtl/sprite_layer_pkg.sv
// Shared types and defaults for the sprite compositing stage:
// pixel word layout, fetch-engine state encoding and signed helpers.
package sprite_layer_pkg;

  localparam int RGB_W     = 12;
  localparam int PIX_W     = RGB_W + 1;
  localparam int SPR_W_DEF = 34;
  localparam int SPR_H_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  // ROM / line-buffer word: bit 12 opaque, bits 11:0 RGB444.
  typedef struct packed {
    logic             opaque;
    logic [RGB_W-1:0] rgb;
  } spr_pix_t;

  // Widen both operands by one bit so the difference of two 16-bit
  // signed positions never overflows.
  function automatic logic signed [16:0] sdiff(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    return $signed({a[15], a}) - $signed({b[15], b});
  endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// One sprite row of pixel words: synchronous write, combinational read.
// Reads beyond the sprite width return a transparent word.
module sprite_line_buf
  import sprite_layer_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int COL_W = 6
) (
  input  logic             pix_clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  spr_pix_t         wr_data,
  input  logic [COL_W-1:0] rd_addr,
  output spr_pix_t         rd_data
);

  localparam logic [COL_W:0] DEPTH = (COL_W + 1)'(SPR_W);

  spr_pix_t mem [SPR_W];

  // NOTE: storage arrays get no reset; every entry is rewritten by a fetch
  // before row_valid allows it to be read, and a reset would cost a mux per bit.
  always_ff @(posedge pix_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ({1'b0, rd_addr} < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/sprite_layer.sv
// Composites one prefetched sprite row over a background colour, one pixel
// per cycle, with syncs re-timed to match the one-cycle colour latency.
module sprite_layer
  import sprite_layer_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int ROM_AW = 10,
  parameter int COL_W  = 6
) (
  input  logic                pix_clk,
  input  logic                pix_rst,
  input  logic signed [15:0]  sx,
  input  logic signed [15:0]  sy,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                de_i,
  input  logic                new_line,
  input  logic                new_frame,
  input  logic                spr_en,
  input  logic signed [15:0]  spr_x,
  input  logic signed [15:0]  spr_y,
  input  logic [RGB_W-1:0]    bg_rgb,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [PIX_W-1:0]    rom_data,
  output logic [RGB_W-1:0]    rgb,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic                busy
);

  localparam logic signed [16:0] SPR_W_S  = 17'(SPR_W);
  localparam logic signed [16:0] SPR_H_S  = 17'(SPR_H);
  localparam logic [ROM_AW-1:0]  SPR_W_A  = ROM_AW'(SPR_W);
  localparam logic [COL_W-1:0]   LAST_COL = COL_W'(SPR_W - 1);

  fetch_state_t       state;
  logic [COL_W-1:0]   col;
  logic               row_valid;
  logic               spr_en_sh;
  logic signed [15:0] spr_x_sh;
  logic signed [15:0] spr_y_sh;

  logic signed [16:0] row;
  logic signed [16:0] col_d;
  logic               row_hit;
  logic               col_hit;
  logic [ROM_AW-1:0]  row_base;

  logic               lb_we;
  logic [COL_W-1:0]   lb_waddr;
  spr_pix_t           lb_rdata;

  assign row      = sdiff(sy, spr_y_sh);
  assign col_d    = sdiff(sx, spr_x_sh);
  assign row_hit  = spr_en_sh && !row[16] && (row < SPR_H_S);
  assign col_hit  = !col_d[16] && (col_d < SPR_W_S);
  assign row_base = row[ROM_AW-1:0] * SPR_W_A;
  assign busy     = (state != ST_IDLE);

  // ROM data lags the address by one cycle, so each FETCH cycle stores the
  // word requested by the previous one and DRAIN stores the last word.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned
    // (which would infer a latch).
    lb_we    = 1'b0;
    lb_waddr = '0;
    if (state == ST_FETCH && col != '0) begin
      lb_we    = 1'b1;
      lb_waddr = col - 1'b1;
    end else if (state == ST_DRAIN) begin
      lb_we    = 1'b1;
      lb_waddr = LAST_COL;
    end
  end

  sprite_line_buf #(
    .SPR_W (SPR_W),
    .COL_W (COL_W)
  ) u_line_buf (
    .pix_clk (pix_clk),
    .wr_en   (lb_we),
    .wr_addr (lb_waddr),
    .wr_data (spr_pix_t'(rom_data)),
    .rd_addr (col_d[COL_W-1:0]),
    .rd_data (lb_rdata)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      state     <= ST_IDLE;
      col       <= '0;
      row_valid <= 1'b0;
      spr_en_sh <= 1'b0;
      spr_x_sh  <= '0;
      spr_y_sh  <= '0;
      rom_addr  <= '0;
      rgb       <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      de        <= 1'b0;
    end else begin
      if (new_frame) begin
        spr_en_sh <= spr_en;
        spr_x_sh  <= spr_x;
        spr_y_sh  <= spr_y;
      end

      if (new_line) begin
        // A new line while busy abandons the partial row.
        if (state != ST_IDLE) begin
          row_valid <= 1'b0;
        end
        state <= ST_CALC;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_CALC: begin
            row_valid <= 1'b0;
            if (row_hit) begin
              col      <= '0;
              rom_addr <= row_base;
              state    <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_FETCH: begin
            col <= col + 1'b1;
            if (col == LAST_COL) begin
              state <= ST_DRAIN;
            end else begin
              rom_addr <= rom_addr + 1'b1;
            end
          end
          ST_DRAIN: begin
            row_valid <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (de_i && row_valid && col_hit && lb_rdata.opaque) begin
        rgb <= lb_rdata.rgb;
      end else if (de_i) begin
        rgb <= bg_rgb;
      end else begin
        rgb <= '0;
      end
      hsync <= hsync_i;
      vsync <= vsync_i;
      de    <= de_i;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer: drives short synthetic scan lines and
// checks colour, fetch timing, ROM addressing, shadowing and reset abort.
module tb_sprite_layer;
  import sprite_layer_pkg::*;

  localparam int H_STA    = -48;
  localparam int H_ACT    = 160;
  localparam int LINE_LEN = H_ACT - H_STA;
  localparam logic [11:0] BG = 12'h5A3;

  logic               pix_clk = 1'b0;
  logic               pix_rst;
  logic signed [15:0] sx, sy;
  logic               hsync_i, vsync_i, de_i;
  logic               new_line, new_frame;
  logic               spr_en;
  logic signed [15:0] spr_x, spr_y;
  logic [11:0]        bg_rgb;
  logic [9:0]         rom_addr;
  logic [12:0]        rom_data;
  logic [11:0]        rgb;
  logic               hsync, vsync, de, busy;

  int          n_checks = 0;
  int          n_bad    = 0;
  int          transp_col = -1;
  logic [11:0] obs_rgb  [LINE_LEN];
  logic [9:0]  obs_addr [LINE_LEN];
  logic        obs_busy [LINE_LEN];
  int          busy_cnt;
  int          sync_bad;

  sprite_layer dut (
    .pix_clk   (pix_clk),
    .pix_rst   (pix_rst),
    .sx        (sx),
    .sy        (sy),
    .hsync_i   (hsync_i),
    .vsync_i   (vsync_i),
    .de_i      (de_i),
    .new_line  (new_line),
    .new_frame (new_frame),
    .spr_en    (spr_en),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .bg_rgb    (bg_rgb),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rgb       (rgb),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .busy      (busy)
  );

  always #5 pix_clk = ~pix_clk;

  // Synchronous ROM: word = {opaque, column}, same for every row.
  function automatic logic [12:0] rom_word(input logic [9:0] a);
    int c;
    c = int'(a) % 34;
    return {(c != transp_col), 12'(c)};
  endfunction

  always @(posedge pix_clk) rom_data <= rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb_at(input int x);
    return obs_rgb[x - H_STA];
  endfunction

  // One scan line starting with new_line at k=0; rst_k>=0 pulses reset there.
  task automatic run_line(input int y, input bit frame, input int rst_k);
    busy_cnt = 0;
    sync_bad = 0;
    for (int k = 0; k < LINE_LEN; k++) begin
      sx        = 16'(k + H_STA);
      sy        = 16'(y);
      new_line  = (k == 0);
      new_frame = frame && (k == 0);
      de_i      = (k + H_STA) >= 0;
      hsync_i   = !(k >= 8 && k < 20);
      vsync_i   = (k % 5) == 0;
      pix_rst   = (k == rst_k);
      @(posedge pix_clk);
      #1;
      obs_rgb[k]  = rgb;
      obs_addr[k] = rom_addr;
      obs_busy[k] = busy;
      if (busy) busy_cnt++;
      if (k != rst_k && (hsync !== hsync_i || vsync !== vsync_i || de !== de_i))
        sync_bad++;
    end
    new_line  = 1'b0;
    new_frame = 1'b0;
    pix_rst   = 1'b0;
  endtask

  initial begin
    pix_rst = 1'b1; sx = 16'sd20; sy = 16'sd10;
    hsync_i = 1'b1; vsync_i = 1'b1; de_i = 1'b1;
    new_line = 1'b0; new_frame = 1'b0;
    spr_en = 1'b0; spr_x = '0; spr_y = '0; bg_rgb = BG;

    // 1. reset during active video, then background only
    repeat (3) @(posedge pix_clk);
    #1;
    check("rst_rgb", rgb, 12'h000);
    check("rst_de", de, 0);
    check("rst_hsync", hsync, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    pix_rst = 1'b0;
    run_line(10, 1'b0, -1);
    check("bg_busy", busy_cnt, 1);
    check("bg_x0", rgb_at(0), BG);
    check("bg_x120", rgb_at(120), BG);
    check("blank_rgb", obs_rgb[5], 12'h000);

    // 2. sprite at (100,50)
    spr_x = 16'sd100; spr_y = 16'sd50; spr_en = 1'b1;
    run_line(50, 1'b1, -1);
    check("fetch_busy36", busy_cnt, 36);
    check("busy_end", obs_busy[36], 0);
    check("l50_x100", rgb_at(100), 12'h000);
    check("l50_x117", rgb_at(117), 12'h011);
    check("l50_x133", rgb_at(133), 12'h021);
    check("l50_x99", rgb_at(99), BG);
    check("l50_x134", rgb_at(134), BG);
    check("sync_align", sync_bad, 0);

    // 3. transparent column 5
    transp_col = 5;
    run_line(51, 1'b0, -1);
    check("tr_x104", rgb_at(104), 12'h004);
    check("tr_x105", rgb_at(105), BG);
    check("tr_x106", rgb_at(106), 12'h006);
    transp_col = -1;

    // 4. vertical bounds
    run_line(49, 1'b0, -1);
    check("y49_busy", busy_cnt, 1);
    check("y49_x110", rgb_at(110), BG);
    run_line(74, 1'b0, -1);
    check("y74_busy", busy_cnt, 1);
    check("y74_x110", rgb_at(110), BG);
    run_line(73, 1'b0, -1);
    check("y73_busy", busy_cnt, 36);
    check("y73_addr_first", obs_addr[1], 782);
    check("y73_addr_last", obs_addr[34], 815);
    check("y73_x100", rgb_at(100), 12'h000);

    // 5. shadowing of spr_y
    spr_y = 16'sd200;
    run_line(61, 1'b0, -1);
    check("sh_mid_x110", rgb_at(110), 12'h00A);
    run_line(50, 1'b1, -1);
    check("sh_y50_busy", busy_cnt, 1);
    check("sh_y50_x110", rgb_at(110), BG);
    run_line(200, 1'b0, -1);
    check("sh_y200_addr", obs_addr[1], 0);
    check("sh_y200_x110", rgb_at(110), 12'h00A);
    run_line(223, 1'b0, -1);
    check("sh_y223_addr", obs_addr[1], 782);
    check("sh_y223_x133", rgb_at(133), 12'h021);
    run_line(224, 1'b0, -1);
    check("sh_y224_busy", busy_cnt, 1);

    // 6. left clipping, disable, reset abort
    spr_x = -16'sd10; spr_y = 16'sd0;
    run_line(0, 1'b1, -1);
    check("clip_x0", rgb_at(0), 12'h00A);
    check("clip_x23", rgb_at(23), 12'h021);
    check("clip_x24", rgb_at(24), BG);
    spr_en = 1'b0;
    run_line(5, 1'b1, -1);
    check("dis_busy", busy_cnt, 1);
    check("dis_x0", rgb_at(0), BG);
    spr_en = 1'b1;
    run_line(3, 1'b1, 10);
    check("abort_pre_busy", obs_busy[9], 1);
    check("abort_busy", obs_busy[10], 0);
    check("abort_x0", rgb_at(0), BG);
    run_line(4, 1'b0, -1);
    check("post_rst_busy", busy_cnt, 1);
    check("post_rst_x0", rgb_at(0), BG);
    run_line(4, 1'b1, -1);
    check("refetch_x0", rgb_at(0), 12'h00A);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
